// File: rtl/tt_bist_harness.sv
// On-chip stimulus/response harness: streams patterns into a DUT, folds the DUT
// responses into a MISR signature and flags pass/fail against a golden value.
module tt_bist_harness #(
  parameter int WIDTH     = 8,
  parameter int OUT_WIDTH = 8,
  parameter int CNT_W     = 16,
  parameter int DUT_LAT   = 1,
  parameter logic [WIDTH-1:0]     LFSR_POLY = 'h1D,
  parameter logic [OUT_WIDTH-1:0] MISR_POLY = 'h1D,
  parameter logic [OUT_WIDTH-1:0] MISR_INIT = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 start,
  input  logic                 abort,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     seed,
  input  logic [CNT_W-1:0]     num_vec,
  input  logic [OUT_WIDTH-1:0] expected_sig,
  input  logic [OUT_WIDTH-1:0] resp_in,
  output logic [WIDTH-1:0]     stim_out,
  output logic [OUT_WIDTH-1:0] signature,
  output logic                 busy,
  output logic                 done,
  output logic                 pass
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | issuing vectors and sampling responses
  // FLUSH | all vectors issued, draining the DUT latency
  // DONE  | signature final, pass valid
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t               state, state_nxt;
  logic [1:0]           mode_q;
  logic [CNT_W-1:0]     num_q, issued, samp_cnt;
  logic [OUT_WIDTH-1:0] exp_q, sig_nxt;
  logic [WIDTH-1:0]     first_vec, next_vec;
  // vld[0] marks a freshly presented vector; vld[DUT_LAT] marks a sample edge
  logic [DUT_LAT:0]     vld;
  logic                 sample, last_sample, advance;
  logic                 load_run, load_zero, run_step, abort_go, finish;

  assign busy = (state == RUN) || (state == FLUSH);
  assign done = (state == DONE);

  assign sample      = vld[DUT_LAT];
  assign last_sample = sample && (samp_cnt == num_q - ONE);
  assign advance     = issued < num_q;
  assign sig_nxt     = {signature[OUT_WIDTH-2:0], 1'b0}
                     ^ (signature[OUT_WIDTH-1] ? MISR_POLY : '0) ^ resp_in;

  always_comb begin
    first_vec = seed;
    if (mode == 2'd2 || (mode == 2'd1 && seed == '0)) first_vec = WIDTH'(1);
  end

  always_comb begin
    next_vec = stim_out;
    case (mode_q)
      2'd0:    next_vec = stim_out + WIDTH'(1);
      2'd1:    next_vec = {stim_out[WIDTH-2:0], 1'b0} ^ (stim_out[WIDTH-1] ? LFSR_POLY : '0);
      2'd2:    next_vec = {stim_out[WIDTH-2:0], stim_out[WIDTH-1]};
      default: next_vec = stim_out;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else if (ena) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_run  = 1'b0;
    load_zero = 1'b0;
    run_step  = 1'b0;
    abort_go  = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          if (num_vec == '0) begin
            load_zero = 1'b1;
            state_nxt = DONE;
          end else begin
            load_run  = 1'b1;
            state_nxt = RUN;
          end
        end
      end
      RUN, FLUSH: begin
        if (abort) begin
          abort_go  = 1'b1;
          state_nxt = IDLE;
        end else begin
          run_step = 1'b1;
          if (last_sample) begin
            finish    = 1'b1;
            state_nxt = DONE;
          end else if (state == RUN && !advance && DUT_LAT > 0) begin
            state_nxt = FLUSH;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stim_out  <= '0;
      signature <= MISR_INIT;
      pass      <= 1'b0;
      mode_q    <= '0;
      num_q     <= '0;
      exp_q     <= '0;
      issued    <= '0;
      samp_cnt  <= '0;
      vld       <= '0;
    end else if (ena) begin
      if (load_run || load_zero) begin
        mode_q    <= mode;
        num_q     <= num_vec;
        exp_q     <= expected_sig;
        signature <= MISR_INIT;
        pass      <= load_zero && (MISR_INIT == expected_sig);
        samp_cnt  <= '0;
        vld       <= '0;
      end
      if (load_run) begin
        stim_out <= first_vec;
        issued   <= ONE;
        vld[0]   <= 1'b1;
      end
      if (run_step) begin
        if (advance) begin
          stim_out <= next_vec;
          issued   <= issued + ONE;
        end
        vld[0] <= advance;
        for (int k = DUT_LAT; k >= 1; k--) vld[k] <= vld[k-1];
        if (sample) begin
          signature <= sig_nxt;
          samp_cnt  <= samp_cnt + ONE;
        end
        if (finish) pass <= (sig_nxt == exp_q);
      end
      if (abort_go) begin
        pass <= 1'b0;
        vld  <= '0;
      end
    end
  end

endmodule
